// File: rtl/flex_timer_pkg.sv
// Shared types and constants for flex_timer_counter and its prescaler.
package flex_timer_pkg;

  localparam int FT_DEF_CNT_BITS      = 4;
  localparam int FT_DEF_PRESCALE_BITS = 4;

  typedef enum logic {
    FT_WRAP    = 1'b0,
    FT_ONESHOT = 1'b1
  } ft_mode_e;

  localparam logic FT_UP   = 1'b0;
  localparam logic FT_DOWN = 1'b1;

endpackage

// File: rtl/flex_timer_counter_prescaler.sv
// Enable-qualified divider: strobes once per prescale_val+1 enabled cycles.
module flex_prescaler
  import flex_timer_pkg::*;
#(
  parameter int PRESCALE_BITS = FT_DEF_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     strobe
);

  logic [PRESCALE_BITS-1:0] pcount;

  // >= rather than == so a shrinking prescale_val cannot strand the phase above it.
  assign strobe = enable && (pcount >= prescale_val);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pcount <= '0;
    end else if (enable) begin
      if (strobe) begin
        pcount <= '0;
      end else begin
        pcount <= pcount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/flex_timer_counter.sv
// Up/down loadable counter with WRAP/ONESHOT modes and rollover pulse.
// Optional prescaler built when FLEX_TIMER_PRESCALER_EN is defined.
module flex_timer_counter
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS  = FT_DEF_CNT_BITS,
  parameter int PRESCALE_BITS = FT_DEF_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     count_down,
  input  logic                     mode,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     rollover_pulse,
  output logic                     done
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic                    flag_q;
  logic                    pulse_q;
  logic                    done_q;

  logic [NUM_CNT_BITS-1:0] next_count;
  logic [NUM_CNT_BITS-1:0] terminal;
  logic                    next_flag;
  logic                    tick_qual;
  logic                    tick;

  // A zero rollover value or a finished one-shot freezes the count.
  assign tick_qual = count_enable && !done_q && (rollover_val != '0);

`ifdef FLEX_TIMER_PRESCALER_EN
  logic pre_strobe;

  flex_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear || load),
    .enable       (count_enable && !done_q),
    .prescale_val (prescale_val),
    .strobe       (pre_strobe)
  );

  assign tick = tick_qual && pre_strobe;
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_val;
  assign tick = tick_qual;
`endif

  always_comb begin
    next_count = count_q;
    terminal   = rollover_val;
    if (count_down == FT_DOWN) begin
      terminal = CNT_ONE;
      if (count_q <= CNT_ONE) begin
        next_count = rollover_val;
      end else begin
        next_count = count_q - CNT_ONE;
      end
    end else begin
      if (count_q >= rollover_val) begin
        next_count = CNT_ONE;
      end else begin
        next_count = count_q + CNT_ONE;
      end
    end
    next_flag = (next_count == terminal);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      count_q <= load_val;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (tick) begin
      count_q <= next_count;
      flag_q  <= next_flag;
      pulse_q <= next_flag && !flag_q;
      if ((ft_mode_e'(mode) == FT_ONESHOT) && next_flag) begin
        done_q <= 1'b1;
      end
    end else begin
      pulse_q <= 1'b0;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign done           = done_q;

endmodule
